// File: rtl/sparse_cop_pkg.sv
// Shared types and helpers for the sparse-matrix coprocessor sequencer.
//   state_t  : sequencer FSM states
//   tag_lsb  : bit position of the tag field inside a packet
//   lane_lsb : bit position of a given lane inside the lane block
package sparse_cop_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StDispatch,
    StWait,
    StTx
  } state_t;

  // Tag sits directly above the lane block.
  function automatic int unsigned tag_lsb(input int unsigned lanes, input int unsigned data_w);
    return lanes * data_w;
  endfunction

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned data_w);
    return lane * data_w;
  endfunction

endpackage

// File: rtl/sparse_pkt_fifo.sv
// Synchronous packet FIFO for the sequencer receive path.
// Ports:
//   clk, resetn : clock, asynchronous active-low reset
//   push, wdata : write request and data; accepted when not full or when popping this cycle
//   pop         : read request; ignored when empty
//   rdata       : head entry (valid while !empty)
//   full, empty : status
//   count       : occupancy, 0..DEPTH
module sparse_pkt_fifo
  import sparse_cop_pkg::*;
#(
  parameter int unsigned WIDTH = 136,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Power-of-two depth: pointers wrap naturally.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/sparse_coprocessor_sequencer.sv
// Control core of the sparse-matrix coprocessor. Buffers packets from the comm block, sends each
// one to the FPU lane bank (compute) or straight back (loopback), captures results on the FPU busy
// falling edge and returns {tag, results} to comm.
// Ports:
//   clk, resetn            : clock, asynchronous active-low reset
//   op                     : 1 compute, 0 loopback; sampled when a packet leaves the FIFO
//   clr_err                : clears overflow/timeout (a same-cycle new error keeps the flag set)
//   rx_valid, rx_data      : incoming packet pulse {tag, lane[LANES-1]..lane[0]}
//   fpu_valid/ready        : operand handshake, fpu_operand carries the lanes
//   fpu_busy, fpu_result   : FPU activity; result valid when busy first samples low
//   tx_valid/ready, tx_data: outgoing packet handshake
//   busy                   : sequencer active or packets queued
//   overflow, timeout      : sticky error flags
//   count                  : FIFO occupancy
module sparse_coprocessor_sequencer
  import sparse_cop_pkg::*;
#(
  parameter int unsigned LANES   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 1024,
  localparam int unsigned OPD_W  = LANES * DATA_W,
  localparam int unsigned PKT_W  = TAG_W + OPD_W,
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op,
  input  logic             clr_err,
  input  logic             rx_valid,
  input  logic [PKT_W-1:0] rx_data,
  output logic             fpu_valid,
  input  logic             fpu_ready,
  output logic [OPD_W-1:0] fpu_operand,
  input  logic             fpu_busy,
  input  logic [OPD_W-1:0] fpu_result,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [PKT_W-1:0] tx_data,
  output logic             busy,
  output logic             overflow,
  output logic             timeout,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned TagLsb = tag_lsb(LANES, DATA_W);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT);

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  // Holds operands until the FPU answers, then the results; loopback sends it back untouched.
  logic [OPD_W-1:0]   data_q, data_d;
  logic               fbusy_q, fbusy_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic               overflow_q, overflow_d;
  logic               timeout_q, timeout_d;

  logic               fifo_pop, fifo_full, fifo_empty;
  logic [PKT_W-1:0]   fifo_rdata;
  logic               rx_drop, timeout_set, fpu_done;

  sparse_pkt_fifo #(
    .WIDTH(PKT_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (rx_valid),
    .wdata (rx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign rx_drop  = rx_valid & fifo_full & ~fifo_pop;
  assign fpu_done = fbusy_q & ~fpu_busy;

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    data_d      = data_q;
    fbusy_d     = fbusy_q;
    timer_d     = timer_q;
    timeout_set = 1'b0;
    fifo_pop    = 1'b0;
    fpu_valid   = 1'b0;
    fpu_operand = '0;
    tx_valid    = 1'b0;
    tx_data     = '0;

    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) state_d = StPop;
      end
      StPop: begin
        fifo_pop = 1'b1;
        tag_d    = fifo_rdata[PKT_W-1:TagLsb];
        data_d   = fifo_rdata[OPD_W-1:0];
        // op only steers this branch, so it is not kept beyond the pop.
        state_d  = op ? StDispatch : StTx;
      end
      StDispatch: begin
        fpu_valid   = 1'b1;
        fpu_operand = data_q;
        if (fpu_ready) begin
          state_d = StWait;
          timer_d = '0;
          fbusy_d = 1'b0;
        end
      end
      StWait: begin
        fbusy_d = fpu_busy;
        // Completion beats expiry when both land in the same cycle.
        if (fpu_done) begin
          data_d  = fpu_result;
          state_d = StTx;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          data_d      = '0;
          timeout_set = 1'b1;
          state_d     = StTx;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StTx: begin
        tx_valid = 1'b1;
        tx_data  = {tag_q, data_q};
        if (tx_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    if (rx_drop)          overflow_d = 1'b1;
    else if (clr_err)     overflow_d = 1'b0;
    if (timeout_set)      timeout_d  = 1'b1;
    else if (clr_err)     timeout_d  = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      tag_q      <= '0;
      data_q     <= '0;
      fbusy_q    <= 1'b0;
      timer_q    <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      fbusy_q    <= fbusy_d;
      timer_q    <= timer_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy     = (state_q != StIdle) | ~fifo_empty;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_sparse_coprocessor_sequencer.sv
module tb_sparse_coprocessor_sequencer;

  localparam int unsigned LANES   = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned OPD_W   = LANES * DATA_W;
  localparam int unsigned PKT_W   = TAG_W + OPD_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             resetn, op, clr_err, rx_valid, tx_ready;
  logic [PKT_W-1:0] rx_data;
  logic             fpu_valid, fpu_ready, fpu_busy;
  logic [OPD_W-1:0] fpu_operand, fpu_result;
  logic             tx_valid, busy, overflow, timeout;
  logic [PKT_W-1:0] tx_data;
  logic [CNT_W-1:0] count;

  logic             stuck;
  int               fcnt;
  logic             pend;
  logic [OPD_W-1:0] fcap;

  int total  = 0;
  int passed = 0;
  logic [PKT_W-1:0] exp_q[$];

  sparse_coprocessor_sequencer #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .op         (op),
    .clr_err    (clr_err),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .fpu_valid  (fpu_valid),
    .fpu_ready  (fpu_ready),
    .fpu_operand(fpu_operand),
    .fpu_busy   (fpu_busy),
    .fpu_result (fpu_result),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .busy       (busy),
    .overflow   (overflow),
    .timeout    (timeout),
    .count      (count)
  );

  always #5 clk = ~clk;

  // Each lane doubled: the FPU's arithmetic in this bench.
  function automatic logic [OPD_W-1:0] dbl(input logic [OPD_W-1:0] v);
    logic [OPD_W-1:0]  r;
    logic [DATA_W-1:0] lane;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = v[i*DATA_W +: DATA_W];
      r[i*DATA_W +: DATA_W] = lane << 1;
    end
    return r;
  endfunction

  function automatic logic [PKT_W-1:0] rnd_pkt(input logic [TAG_W-1:0] tag);
    logic [PKT_W-1:0] p;
    p = '0;
    p[PKT_W-1 -: TAG_W] = tag;
    for (int i = 0; i < LANES; i++) p[i*DATA_W +: DATA_W] = DATA_W'($urandom());
    return p;
  endfunction

  function automatic logic [PKT_W-1:0] exp_of(input logic [PKT_W-1:0] p, input logic opv);
    if (opv) return {p[PKT_W-1 -: TAG_W], dbl(p[OPD_W-1:0])};
    return p;
  endfunction

  // FPU: random accept delay, busy for 5 cycles, result = doubled lanes; stuck keeps busy high.
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        pend = 1'b0; fcnt = 0; fpu_busy = 1'b0; fpu_ready = 1'b0; fpu_result = '0; fcap = '0;
      end else if (pend) begin
        pend = 1'b0; fpu_ready = 1'b0; fpu_busy = 1'b1; fcnt = 5;
      end else if (fcnt > 0) begin
        fcnt--;
        if (fcnt == 0 && !stuck) begin
          fpu_busy = 1'b0; fpu_result = dbl(fcap);
        end
      end else if (fpu_busy && !stuck) begin
        fpu_busy = 1'b0;
      end else if (fpu_valid) begin
        fpu_ready = ($urandom_range(0, 2) == 0);
        if (fpu_ready) begin
          pend = 1'b1; fcap = fpu_operand;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [PKT_W-1:0] obs, input logic [PKT_W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  // Random rx traffic plus tx handshaking; every tx packet is matched against exp_q in order.
  task automatic stream(input string name, input int n, input logic opv, input int rdy_period,
                        input int budget);
    int               sent;
    int               cyc;
    logic             stall;
    logic [PKT_W-1:0] held;
    logic [PKT_W-1:0] p;
    sent = 0; cyc = 0; stall = 1'b0; held = '0;
    op = opv;
    while ((sent < n || exp_q.size() != 0) && cyc < budget) begin
      tick();
      cyc++;
      if (stall) chk({name, "_stable"}, tx_data, held);
      rx_valid = (sent < n) && ($urandom_range(0, 1) == 0);
      if (rx_valid) begin
        p = rnd_pkt(TAG_W'($urandom()));
        rx_data = p;
        exp_q.push_back(exp_of(p, opv));
        sent++;
      end
      tx_ready = (rdy_period == 0) ? ($urandom_range(0, 1) == 0) : (cyc % rdy_period == 0);
      stall = tx_valid && !tx_ready;
      held  = tx_data;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk({name, "_extra"}, tx_valid, 0);
        else chk({name, "_data"}, tx_data, exp_q.pop_front());
      end
    end
    tick();
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    chk({name, "_left"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [PKT_W-1:0] p;
    int               k;
    stuck = 1'b0; resetn = 1'b0; op = 1'b0; clr_err = 1'b0;
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;

    #12;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_fpu_valid", fpu_valid, 0);
    chk("rst_fpu_operand", fpu_operand, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {overflow, timeout}, 0);
    chk("rst_count", count, 0);
    tick(); resetn = 1'b1; tick();

    // Loopback latency: rx at N, tx_valid at N+3.
    p = {8'hA5, 32'd4, 32'd3, 32'd2, 32'd1};
    op = 1'b0; rx_data = p; rx_valid = 1'b1;
    tick(); rx_valid = 1'b0;
    chk("lb_count", count, 1);
    chk("lb_busy", busy, 1);
    chk("lb_tx_n1", tx_valid, 0);
    tick(); chk("lb_tx_n2", tx_valid, 0);
    tick(); chk("lb_tx_n3", tx_valid, 1);
    chk("lb_data", tx_data, p);
    tx_ready = 1'b1;
    tick(); tx_ready = 1'b0;
    chk("lb_tx_after", tx_valid, 0);
    chk("lb_busy_after", busy, 0);

    // Compute: lanes doubled, fpu_valid drops right after acceptance.
    op = 1'b1; rx_data = p; rx_valid = 1'b1;
    tick(); rx_valid = 1'b0;
    k = 0;
    while (!(fpu_valid && fpu_ready) && k < 50) begin
      if (fpu_valid) chk("cmp_operand", fpu_operand, p[OPD_W-1:0]);
      tick(); k++;
    end
    chk("cmp_handshake", fpu_valid && fpu_ready, 1);
    tick();
    chk("cmp_valid_drop", fpu_valid, 0);
    k = 0;
    while (!tx_valid && k < 50) begin tick(); k++; end
    chk("cmp_data", tx_data, {8'hA5, 32'd8, 32'd6, 32'd4, 32'd2});
    chk("cmp_no_timeout", timeout, 0);
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;

    // Overflow: one packet held in tx, 16 queued, the next is dropped.
    op = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      rx_data = rnd_pkt(TAG_W'(i));
      rx_valid = 1'b1;
      if (i <= 17) exp_q.push_back(rx_data);
      tick();
    end
    rx_valid = 1'b0;
    tick();
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("ovf_clear", overflow, 0);
    clr_err = 1'b1; rx_valid = 1'b1; rx_data = rnd_pkt(8'hEE);
    tick(); clr_err = 1'b0; rx_valid = 1'b0;
    chk("ovf_drop_beats_clear", overflow, 1);
    chk("ovf_count_held", count, 16);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("ovf_clear2", overflow, 0);
    stream("ovf_drain", 0, 1'b0, 1, 500);

    // Timeout: FPU never drops busy.
    stuck = 1'b1; op = 1'b1;
    p = rnd_pkt(8'h3C); rx_data = p; rx_valid = 1'b1;
    tick(); rx_valid = 1'b0;
    k = 0;
    while (!(fpu_valid && fpu_ready) && k < 50) begin tick(); k++; end
    chk("to_handshake", fpu_valid && fpu_ready, 1);
    tick(); k = 1;
    while (!tx_valid && k < 40) begin
      if (k == 8) chk("to_flag_before", timeout, 0);
      tick(); k++;
    end
    chk("to_wait_cycles", k - 1, TIMEOUT);
    chk("to_flag", timeout, 1);
    chk("to_data", tx_data, {8'h3C, {OPD_W{1'b0}}});
    tx_ready = 1'b1; tick(); tx_ready = 1'b0;
    stuck = 1'b0;
    tick();
    chk("to_sticky", timeout, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("to_clear", timeout, 0);

    // Backpressure and ordering, tx_ready 1-in-3.
    stream("bp", 3, 1'b0, 3, 300);

    // Randomized traffic in both modes.
    stream("rnd_cmp", 10, 1'b1, 0, 3000);
    stream("rnd_lb", 12, 1'b0, 0, 2000);

    // Reset in the middle of WAIT with packets queued.
    stuck = 1'b1; op = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rx_data = rnd_pkt(TAG_W'(8'h50 + i)); rx_valid = 1'b1; tick();
    end
    rx_valid = 1'b0;
    k = 0;
    while (!(fpu_valid && fpu_ready) && k < 50) begin tick(); k++; end
    tick(); tick();
    chk("rstw_pre_count", count, 2);
    chk("rstw_pre_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk("rstw_tx_valid", tx_valid, 0);
    chk("rstw_tx_data", tx_data, 0);
    chk("rstw_fpu_valid", fpu_valid, 0);
    chk("rstw_fpu_operand", fpu_operand, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_count", count, 0);
    chk("rstw_flags", {overflow, timeout}, 0);
    tick(); resetn = 1'b1; stuck = 1'b0;
    tick();
    stream("post_rst", 2, 1'b0, 1, 200);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
